crc7_32_dec: RTL and testbench



---
 rtl/crc7_32_pkg.sv | 37 +++
 rtl/crc7_32_syn.sv | 13 +
 rtl/crc7_32_dec.sv | 105 ++++++++++
 tb/tb_crc7_32_dec.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/crc7_32_pkg.sv
// crc7_32_pkg: shared constants, codeword field slices and the CRC-7 parity
// function (generator x^7+x^6+x^2+1) used by both encoder and decoder.
// Data bit i of data[0:31] weighs x^(7+i); par[j] is the coefficient of x^j.
package crc7_32_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned PAR_W    = 7;
   localparam int unsigned CODE_W   = PAR_W + DATA_W;

   // Codeword slices in [0:CODE_W-1] index order: {par[0:6], data[0:31]}
   localparam int unsigned PAR_LSB  = 0;
   localparam int unsigned PAR_MSB  = PAR_W - 1;
   localparam int unsigned DATA_LSB = PAR_W;
   localparam int unsigned DATA_MSB = CODE_W - 1;

   // Generator low-order taps (x^6 + x^2 + 1)
   localparam logic [PAR_W-1:0] CRC7_POLY = 7'h45;

   localparam int unsigned CNT_W_DEF = 16;

   // Remainder of data(x)*x^7 mod g(x), highest-weight data bit shifted in first
   function automatic logic [0:PAR_W-1] crc7_32_par(input logic [0:DATA_W-1] data);
      logic [PAR_W-1:0] rem;
      logic             fb;
      logic [0:PAR_W-1] par;
      rem = '0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb  = rem[PAR_W-1] ^ data[i];
         rem = {rem[PAR_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
      for (int j = 0; j < PAR_W; j++) begin
         par[j] = rem[j];
      end
      return par;
   endfunction

endpackage

// File: rtl/crc7_32_syn.sv
// crc7_32_syn: combinational syndrome of a 39-bit codeword
// (recomputed check bits XOR received check bits).
module crc7_32_syn
   import crc7_32_pkg::*;
(
   input  logic [0:CODE_W-1] code,
   output logic [0:PAR_W-1]  syn_c
);

   // Recompute parity over the data field and compare with the carried bits
   assign syn_c = crc7_32_par(code[DATA_LSB:DATA_MSB]) ^ code[PAR_LSB:PAR_MSB];

endmodule

// File: rtl/crc7_32_dec.sv
// crc7_32_dec: two-stage CRC-7/32 check pipeline with valid/ready handshake
// on both sides, per-word error flag, syndrome and sticky error status.
// Optional saturating error counter o_err_cnt: define CRC7_DEC_ERRCNT_EN.
module crc7_32_dec
   import crc7_32_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              i_valid,
   output logic              i_ready,
   input  logic [0:CODE_W-1] i_code,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [0:DATA_W-1] o_data,
   output logic              o_err,
   output logic [0:PAR_W-1]  o_syn,
   output logic              o_err_sticky,
   input  logic              clr_err
`ifdef CRC7_DEC_ERRCNT_EN
   ,
   output logic [CNT_W-1:0]  o_err_cnt
`endif
);

   logic              s1_valid;
   logic [0:CODE_W-1] s1_code;
   logic [0:PAR_W-1]  s1_syn_c;
   logic              s1_load;
   logic              s2_load;
   logic              out_xfer;
   logic              err_xfer;
   logic              clr_act;

   // Stage 1 frees up whenever it is empty or is about to advance
   assign i_ready  = enable & (~s1_valid | ~o_valid | o_ready);
   assign s1_load  = enable & i_valid & i_ready;
   assign s2_load  = enable & s1_valid & (~o_valid | o_ready);
   assign out_xfer = enable & o_valid & o_ready;
   assign err_xfer = out_xfer & o_err;
   assign clr_act  = enable & clr_err;

   crc7_32_syn u_syn (
      .code  (s1_code),
      .syn_c (s1_syn_c)
   );

   // Stage 1: input capture register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_code  <= i_code;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: output register, held while the consumer stalls
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_syn   <= '0;
         o_err   <= 1'b0;
      end else if (s2_load) begin
         o_valid <= 1'b1;
         o_data  <= s1_code[DATA_LSB:DATA_MSB];
         o_syn   <= s1_syn_c;
         o_err   <= |s1_syn_c;
      end else if (out_xfer) begin
         o_valid <= 1'b0;
      end
   end

   // Sticky error: a delivered bad word beats a simultaneous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_err_sticky <= 1'b0;
      end else if (err_xfer) begin
         o_err_sticky <= 1'b1;
      end else if (clr_act) begin
         o_err_sticky <= 1'b0;
      end
   end

`ifdef CRC7_DEC_ERRCNT_EN
   // Saturating count of delivered bad words; clear plus bad word restarts at 1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_err_cnt <= '0;
      end else if (clr_act) begin
         o_err_cnt <= err_xfer ? CNT_W'(1) : '0;
      end else if (err_xfer && (o_err_cnt != {CNT_W{1'b1}})) begin
         o_err_cnt <= o_err_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_crc7_32_dec.sv
// tb_crc7_32_dec: directed self-checking bench for crc7_32_dec.
// Expected parity values were worked by hand for generator x^7+x^6+x^2+1.
// With CRC7_DEC_ERRCNT_EN defined the DUT is built with CNT_W=2.
module tb_crc7_32_dec;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        i_valid;
   logic        i_ready;
   logic [0:38] i_code;
   logic        o_valid;
   logic        o_ready;
   logic [0:31] o_data;
   logic        o_err;
   logic [0:6]  o_syn;
   logic        o_err_sticky;
   logic        clr_err;
`ifdef CRC7_DEC_ERRCNT_EN
   logic [1:0]  o_err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [0:38] w_code [8];
   logic [31:0] w_data [8];
   logic [6:0]  w_syn  [8];

   crc7_32_dec #(.CNT_W(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .i_valid      (i_valid),
      .i_ready      (i_ready),
      .i_code       (i_code),
      .o_valid      (o_valid),
      .o_ready      (o_ready),
      .o_data       (o_data),
      .o_err        (o_err),
      .o_syn        (o_syn),
      .o_err_sticky (o_err_sticky),
      .clr_err      (clr_err)
`ifdef CRC7_DEC_ERRCNT_EN
      ,
      .o_err_cnt    (o_err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word, check exact 2-cycle latency and contents, then consume it
   task automatic deliver(input string tag, input logic [0:38] code,
                          input logic [31:0] exp_data, input logic [6:0] exp_syn,
                          input logic clr_at_xfer);
      i_code  = code;
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      chk({tag, "_lat1"}, o_valid, 1'b0);
      step();
      chk({tag, "_valid"}, o_valid, 1'b1);
      chk({tag, "_data"}, o_data, exp_data);
      chk({tag, "_syn"}, o_syn, exp_syn);
      chk({tag, "_err"}, o_err, exp_syn != 7'd0);
      clr_err = clr_at_xfer;
      step();
      clr_err = 1'b0;
      chk({tag, "_drop"}, o_valid, 1'b0);
   endtask

   // Stream all table words with a stall window and an enable-low window
   task automatic run_stream(input string tag, input int st_lo, input int st_hi,
                             input int dis_lo, input int dis_hi);
      int          in_idx = 0;
      int          out_idx = 0;
      logic        prev_hold = 1'b0;
      logic [31:0] h_data = '0;
      logic [6:0]  h_syn = '0;
      logic        acc;
      logic        xfer;
      for (int c = 0; c < 60 && out_idx < 8; c++) begin
         o_ready = !(c >= st_lo && c < st_hi);
         enable  = !(c >= dis_lo && c < dis_hi);
         i_valid = (in_idx < 8);
         i_code  = (in_idx < 8) ? w_code[in_idx] : 39'h0;
         #1;
         if (prev_hold) begin
            chk({tag, "_hold_valid"}, o_valid, 1'b1);
            chk({tag, "_hold_data"}, o_data, h_data);
            chk({tag, "_hold_syn"}, o_syn, h_syn);
         end
         chk({tag, "_i_ready"}, i_ready, enable && (((in_idx - out_idx) < 2) || o_ready));
         acc  = i_valid & i_ready;
         xfer = o_valid & o_ready & enable;
         if (xfer) begin
            chk({tag, "_data"}, o_data, w_data[out_idx]);
            chk({tag, "_syn"}, o_syn, w_syn[out_idx]);
            chk({tag, "_err"}, o_err, w_syn[out_idx] != 7'd0);
         end
         prev_hold = o_valid & !xfer;
         h_data    = o_data;
         h_syn     = o_syn;
         @(posedge clk);
         #1;
         if (acc) in_idx++;
         if (xfer) out_idx++;
      end
      chk({tag, "_count"}, out_idx, 8);
      i_valid = 1'b0;
      o_ready = 1'b1;
      enable  = 1'b1;
   endtask

   initial begin
      // Word table: {check[0:6], data[0:31]}, syndrome worked by hand
      w_code[0] = {7'b0001101, 32'h00000001}; w_data[0] = 32'h00000001; w_syn[0] = 7'b0000000;
      w_code[1] = {7'b0000000, 32'h40000000}; w_data[1] = 32'h40000000; w_syn[1] = 7'b1111001;
      w_code[2] = {7'b0101000, 32'hC0000000}; w_data[2] = 32'hC0000000; w_syn[2] = 7'b0000000;
      w_code[3] = {7'b0000000, 32'h80000001}; w_data[3] = 32'h80000001; w_syn[3] = 7'b1011100;
      w_code[4] = {7'b0000000, 32'hFFFFFFFF}; w_data[4] = 32'hFFFFFFFF; w_syn[4] = 7'b1100101;
      w_code[5] = {7'b0110100, 32'h7FFFFFFF}; w_data[5] = 32'h7FFFFFFF; w_syn[5] = 7'b0000000;
      w_code[6] = {7'b0000111, 32'h00000000}; w_data[6] = 32'h00000000; w_syn[6] = 7'b0000111;
      w_code[7] = {7'b1111111, 32'h80000000}; w_data[7] = 32'h80000000; w_syn[7] = 7'b0101110;

      reset_n = 1'b0;
      enable  = 1'b1;
      i_valid = 1'b0;
      i_code  = '0;
      o_ready = 1'b1;
      clr_err = 1'b0;
      step();
      step();
      chk("rst_o_valid", o_valid, 1'b0);
      chk("rst_o_data", o_data, 32'h0);
      chk("rst_o_err", o_err, 1'b0);
      chk("rst_o_syn", o_syn, 7'h0);
      chk("rst_sticky", o_err_sticky, 1'b0);
      reset_n = 1'b1;
      #1;
      chk("rst_i_ready", i_ready, 1'b1);
      step();

      // Basic vectors
      deliver("zero", 39'h0, 32'h0, 7'b0000000, 1'b0);
      deliver("ones_ok", {7'b1100101, 32'hFFFFFFFF}, 32'hFFFFFFFF, 7'b0000000, 1'b0);
      chk("sticky_clean", o_err_sticky, 1'b0);
      deliver("ones_flip0", {7'b1100101, 32'h7FFFFFFF}, 32'h7FFFFFFF, 7'b1010001, 1'b0);
      chk("sticky_set", o_err_sticky, 1'b1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("sticky_clr", o_err_sticky, 1'b0);
      deliver("bit0_ok", {7'b1010001, 32'h80000000}, 32'h80000000, 7'b0000000, 1'b0);
      deliver("bit0_nochk", {7'b0000000, 32'h80000000}, 32'h80000000, 7'b1010001, 1'b0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("sticky_clr2", o_err_sticky, 1'b0);
      deliver("bit31", {7'b0000000, 32'h00000001}, 32'h00000001, 7'b0001101, 1'b1);
      chk("sticky_set_wins", o_err_sticky, 1'b1);

      // Streams: output stall, then enable low
      run_stream("stall", 3, 8, 0, 0);
      run_stream("enable", 0, 0, 3, 6);

      // Reset with two words in flight
      chk("pre_rst_sticky", o_err_sticky, 1'b1);
      o_ready = 1'b0;
      i_code  = w_code[1];
      i_valid = 1'b1;
      step();
      i_code  = w_code[3];
      step();
      i_valid = 1'b0;
      chk("pre_rst_valid", o_valid, 1'b1);
      chk("pre_rst_data", o_data, 32'h40000000);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", o_valid, 1'b0);
      chk("mid_rst_data", o_data, 32'h0);
      chk("mid_rst_err", o_err, 1'b0);
      chk("mid_rst_syn", o_syn, 7'h0);
      chk("mid_rst_sticky", o_err_sticky, 1'b0);
      step();
      reset_n = 1'b1;
      o_ready = 1'b1;
      #1;
      chk("post_rst_i_ready", i_ready, 1'b1);
      step();
      step();
      chk("post_rst_no_output", o_valid, 1'b0);

`ifdef CRC7_DEC_ERRCNT_EN
      chk("cnt_reset", o_err_cnt, 2'd0);
      for (int k = 0; k < 5; k++) begin
         deliver("cnt_word", w_code[1], w_data[1], w_syn[1], 1'b0);
      end
      chk("cnt_saturate", o_err_cnt, 2'd3);
      deliver("cnt_clr_word", w_code[3], w_data[3], w_syn[3], 1'b1);
      chk("cnt_clr_coincide", o_err_cnt, 2'd1);
      chk("cnt_clr_sticky", o_err_sticky, 1'b1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("cnt_clr", o_err_cnt, 2'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
